// File: rtl/pipe_hazard_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// The master side is the datapath, which reports hazards. The slave side is the controller, which drives stall and bubble.
interface pipe_hazard_if #(
  parameter int NREG  = 4,
  parameter int CNT_W = 64
);
  logic             fetch_i_valid;
  logic [4:0]       decode_i_rs1;
  logic [4:0]       decode_i_rs2;
  logic             decode_i_use_rs1;
  logic             decode_i_use_rs2;
  logic [4:0]       regE_i_rd;
  logic             regE_i_is_load;
  logic             execute_i_need_jump;
  logic             execute_i_busy;
  logic             memory_i_busy;

  logic             pc_stall;
  logic [NREG-1:0]  reg_stall;
  logic [NREG-1:0]  reg_bubble;
  logic             jump_take;
  logic [NREG-1:0]  stage_valid;
  logic             commit;
  logic [CNT_W-1:0] perf_cycle;
  logic [CNT_W-1:0] perf_instret;
  logic [CNT_W-1:0] perf_stall;
  logic [CNT_W-1:0] perf_flush;
  logic             hang;

  modport master (
    output fetch_i_valid, decode_i_rs1, decode_i_rs2, decode_i_use_rs1, decode_i_use_rs2,
           regE_i_rd, regE_i_is_load, execute_i_need_jump, execute_i_busy, memory_i_busy,
    input  pc_stall, reg_stall, reg_bubble, jump_take, stage_valid, commit,
           perf_cycle, perf_instret, perf_stall, perf_flush, hang
  );

  modport slave (
    input  fetch_i_valid, decode_i_rs1, decode_i_rs2, decode_i_use_rs1, decode_i_use_rs2,
           regE_i_rd, regE_i_is_load, execute_i_need_jump, execute_i_busy, memory_i_busy,
    output pc_stall, reg_stall, reg_bubble, jump_take, stage_valid, commit,
           perf_cycle, perf_instret, perf_stall, perf_flush, hang
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble controller for the in-order pipeline. It tracks a valid bit per register and resolves hazards in priority order:
// memory busy, then execute busy, then jump, then load-use.
module pipe_hazard_ctrl #(
  parameter int NREG       = 4,
  parameter int EX_IDX     = 1,
  parameter int MEM_IDX    = 2,
  parameter int CNT_W      = 64,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  pipe_hazard_if.slave hz
);
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(WDOG_LIMIT);
  localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // These masks select registers 0..EX_IDX or 0..MEM_IDX.
  localparam logic [NREG-1:0] EX_LOW  = {{(NREG-EX_IDX-1){1'b0}},  {(EX_IDX+1){1'b1}}};
  localparam logic [NREG-1:0] MEM_LOW = {{(NREG-MEM_IDX-1){1'b0}}, {(MEM_IDX+1){1'b1}}};

  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_LOADUSE,
    HZ_JUMP,
    HZ_EXBUSY,
    HZ_MEMBUSY
  } hazard_e;

  hazard_e          hazard;
  logic             loadUse;
  logic             pcStall;
  logic             jumpTake;
  logic [NREG-1:0]  stallRaw;
  logic [NREG-1:0]  bubbleRaw;
  logic [NREG-1:0]  stallOut;
  logic [NREG-1:0]  validReg;
  logic [NREG-1:0]  validNext;
  logic [NREG-1:0]  validPrev;
  logic [CNT_W-1:0] perfCycleReg;
  logic [CNT_W-1:0] perfInstretReg;
  logic [CNT_W-1:0] perfStallReg;
  logic [CNT_W-1:0] perfFlushReg;
  logic [WD_W-1:0]  wdogReg;
  logic [WD_W-1:0]  wdogNext;
  logic             hangReg;

  assign loadUse = hz.regE_i_is_load && validReg[EX_IDX] && (hz.regE_i_rd != 5'd0) &&
                   ((hz.decode_i_use_rs1 && (hz.decode_i_rs1 == hz.regE_i_rd)) ||
                    (hz.decode_i_use_rs2 && (hz.decode_i_rs2 == hz.regE_i_rd)));

  always_comb begin
    hazard = HZ_NONE;
    if (hz.memory_i_busy)
      hazard = HZ_MEMBUSY;
    else if (hz.execute_i_busy)
      hazard = HZ_EXBUSY;
    else if (hz.execute_i_need_jump)
      hazard = HZ_JUMP;
    else if (loadUse)
      hazard = HZ_LOADUSE;
  end

  // A jump that arrives under busy is dropped here. It re-asserts from regE once the busy condition clears.
  always_comb begin
    stallRaw  = '0;
    bubbleRaw = '0;
    pcStall   = 1'b0;
    jumpTake  = 1'b0;
    if (rst) begin
      bubbleRaw = '1;
    end else begin
      case (hazard)
        HZ_MEMBUSY: begin
          pcStall               = 1'b1;
          stallRaw              = MEM_LOW;
          bubbleRaw[MEM_IDX+1]  = 1'b1;
        end
        HZ_EXBUSY: begin
          pcStall               = 1'b1;
          stallRaw              = EX_LOW;
          bubbleRaw[EX_IDX+1]   = 1'b1;
        end
        HZ_JUMP: begin
          jumpTake              = 1'b1;
          bubbleRaw             = EX_LOW;
        end
        HZ_LOADUSE: begin
          pcStall               = 1'b1;
          stallRaw[0]           = 1'b1;
          bubbleRaw[EX_IDX]     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stallOut = stallRaw & ~bubbleRaw;

  assign validPrev = {validReg[NREG-2:0], hz.fetch_i_valid};
  for (genvar gi = 0; gi < NREG; gi++) begin : g_valid
    assign validNext[gi] = bubbleRaw[gi] ? 1'b0 :
                           stallOut[gi]  ? validReg[gi] : validPrev[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      validReg <= '0;
    else
      validReg <= validNext;
  end

  assign wdogNext = !pcStall ? '0 :
                    (wdogReg == WD_LIMIT) ? wdogReg : wdogReg + WD_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfCycleReg   <= '0;
      perfInstretReg <= '0;
      perfStallReg   <= '0;
      perfFlushReg   <= '0;
      wdogReg        <= '0;
      hangReg        <= 1'b0;
    end else begin
      perfCycleReg <= perfCycleReg + CNT_ONE;
      if (validReg[NREG-1])
        perfInstretReg <= perfInstretReg + CNT_ONE;
      if (pcStall)
        perfStallReg <= perfStallReg + CNT_ONE;
      if (jumpTake)
        perfFlushReg <= perfFlushReg + CNT_ONE;
      wdogReg <= wdogNext;
      if (wdogNext == WD_LIMIT)
        hangReg <= 1'b1;
    end
  end

  assign hz.pc_stall     = pcStall;
  assign hz.reg_stall    = stallOut;
  assign hz.reg_bubble   = bubbleRaw;
  assign hz.jump_take    = jumpTake;
  assign hz.stage_valid  = validReg;
  assign hz.commit       = validReg[NREG-1];
  assign hz.perf_cycle   = perfCycleReg;
  assign hz.perf_instret = perfInstretReg;
  assign hz.perf_stall   = perfStallReg;
  assign hz.perf_flush   = perfFlushReg;
  assign hz.hang         = hangReg;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. A cycle model built around "frozen prefix / gap / flush range" is compared at every falling edge.
// Directed scenarios also pin hand-computed literal values.
module tb_pipe_hazard_ctrl;
  localparam int NREG    = 4;
  localparam int EX_IDX  = 1;
  localparam int MEM_IDX = 2;
  localparam int CNT_W   = 64;
  localparam int WDOG    = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_if #(.NREG(NREG), .CNT_W(CNT_W)) hz();

  pipe_hazard_ctrl #(
    .NREG(NREG), .EX_IDX(EX_IDX), .MEM_IDX(MEM_IDX), .CNT_W(CNT_W), .WDOG_LIMIT(WDOG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz(hz)
  );

  int nChecks = 0;
  int nFail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The model state is the committed occupancy of each register, plus the counters.
  bit          mV [NREG] = '{default: 1'b0};
  bit          nV [NREG] = '{default: 1'b0};
  logic [63:0] mCycle = '0, mInstret = '0, mStall = '0, mFlush = '0;
  logic [63:0] nCycle = '0, nInstret = '0, nStall = '0, nFlush = '0;
  int          mWdog = 0, nWdog = 0;
  bit          mHang = 1'b0, nHang = 1'b0;

  always @(negedge clk) begin : p_model_cmp
    int frozen, gap, flushTop;
    bit ePs, eJt, lu;
    bit eBub [NREG];
    bit eStall [NREG];
    logic [NREG-1:0] expStall, expBub, expValid;
    // Each hazard freezes a low prefix of the registers. It either opens a one-slot gap or flushes a low range.
    frozen = 0; gap = -1; flushTop = -1; eJt = 1'b0;
    lu = hz.regE_i_is_load && mV[EX_IDX] && (hz.regE_i_rd != 0) &&
         ((hz.decode_i_use_rs1 && hz.decode_i_rs1 == hz.regE_i_rd) ||
          (hz.decode_i_use_rs2 && hz.decode_i_rs2 == hz.regE_i_rd));
    if (rst) flushTop = NREG - 1;
    else if (hz.memory_i_busy) begin frozen = MEM_IDX + 1; gap = MEM_IDX + 1; end
    else if (hz.execute_i_busy) begin frozen = EX_IDX + 1; gap = EX_IDX + 1; end
    else if (hz.execute_i_need_jump) begin flushTop = EX_IDX; eJt = 1'b1; end
    else if (lu) begin frozen = 1; gap = EX_IDX; end
    ePs = (frozen > 0);
    for (int k = 0; k < NREG; k++) begin
      eBub[k]     = (k == gap) || (k <= flushTop);
      eStall[k]   = (k < frozen) && !eBub[k];
      expBub[k]   = eBub[k];
      expStall[k] = eStall[k];
      expValid[k] = mV[k];
    end
    chk("m_pc_stall",    hz.pc_stall,     ePs);
    chk("m_reg_stall",   hz.reg_stall,    expStall);
    chk("m_reg_bubble",  hz.reg_bubble,   expBub);
    chk("m_jump_take",   hz.jump_take,    eJt);
    chk("m_stage_valid", hz.stage_valid,  expValid);
    chk("m_commit",      hz.commit,       mV[NREG-1]);
    chk("m_perf_cycle",  hz.perf_cycle,   mCycle);
    chk("m_perf_instret",hz.perf_instret, mInstret);
    chk("m_perf_stall",  hz.perf_stall,   mStall);
    chk("m_perf_flush",  hz.perf_flush,   mFlush);
    chk("m_hang",        hz.hang,         mHang);
    if (rst) begin
      nV = '{default: 1'b0};
      nCycle = '0; nInstret = '0; nStall = '0; nFlush = '0; nWdog = 0; nHang = 1'b0;
    end else begin
      for (int k = 0; k < NREG; k++)
        nV[k] = eBub[k] ? 1'b0 : eStall[k] ? mV[k] : (k == 0) ? hz.fetch_i_valid : mV[k-1];
      nCycle   = mCycle + 1;
      nInstret = mInstret + (mV[NREG-1] ? 1 : 0);
      nStall   = mStall + (ePs ? 1 : 0);
      nFlush   = mFlush + (eJt ? 1 : 0);
      nWdog    = ePs ? ((mWdog + 1 > WDOG) ? WDOG : mWdog + 1) : 0;
      nHang    = mHang || (nWdog == WDOG);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mV <= '{default: 1'b0};
      mCycle <= '0; mInstret <= '0; mStall <= '0; mFlush <= '0; mWdog <= 0; mHang <= 1'b0;
    end else begin
      mV <= nV;
      mCycle <= nCycle; mInstret <= nInstret; mStall <= nStall; mFlush <= nFlush;
      mWdog <= nWdog; mHang <= nHang;
    end
  end

  task automatic clearIn();
    hz.decode_i_rs1 = 5'd0;        hz.decode_i_rs2 = 5'd0;
    hz.decode_i_use_rs1 = 1'b0;    hz.decode_i_use_rs2 = 1'b0;
    hz.regE_i_rd = 5'd0;           hz.regE_i_is_load = 1'b0;
    hz.execute_i_need_jump = 1'b0; hz.execute_i_busy = 1'b0;
    hz.memory_i_busy = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setLoadUse();
    hz.regE_i_is_load = 1'b1; hz.regE_i_rd = 5'd5;
    hz.decode_i_rs1 = 5'd5;   hz.decode_i_use_rs1 = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    hz.fetch_i_valid = 1'b0;
    clearIn();
    repeat (2) @(posedge clk);
    #2;
    $display("reset: checking held-reset outputs");
    chk("rst_bubble", hz.reg_bubble, 4'b1111);
    chk("rst_stall",  hz.reg_stall,  4'b0000);
    chk("rst_valid",  hz.stage_valid, 4'b0000);
    chk("rst_cycle",  hz.perf_cycle, 64'd0);

    @(posedge clk); #1;
    rst = 1'b0;
    hz.fetch_i_valid = 1'b1;
    $display("straight-line: fetch valid from reset release");
    for (int c = 1; c <= NREG; c++) begin
      step();
      if (c == NREG - 1) chk("t1_commit_early", hz.commit, 1'b0);
      if (c == NREG)     chk("t1_commit_first", hz.commit, 1'b1);
    end
    repeat (10) step();
    chk("t1_instret10", hz.perf_instret, 64'd10);
    chk("t1_cycle14",   hz.perf_cycle,   64'd14);

    $display("load-use: load rd=5 against decode rs1=5");
    setLoadUse();
    #1;
    chk("t2_pc_stall", hz.pc_stall,   1'b1);
    chk("t2_stall",    hz.reg_stall,  4'b0001);
    chk("t2_bubble",   hz.reg_bubble, 4'b0010);
    step();
    chk("t2_one_cycle", hz.pc_stall,    1'b0);
    chk("t2_valid",     hz.stage_valid, 4'b1101);
    clearIn();
    step();

    $display("jump: redirect with load-use also present");
    setLoadUse();
    hz.execute_i_need_jump = 1'b1;
    #1;
    chk("t3_jump_take", hz.jump_take,  1'b1);
    chk("t3_bubble",    hz.reg_bubble, 4'b0011);
    chk("t3_pc_stall",  hz.pc_stall,   1'b0);
    chk("t3_stall",     hz.reg_stall,  4'b0000);
    step();
    chk("t3_flush1", hz.perf_flush, 64'd1);
    chk("t3_stall1", hz.perf_stall, 64'd1);
    clearIn();

    $display("memory busy x3 with pending jump");
    hz.memory_i_busy = 1'b1;
    hz.execute_i_need_jump = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_stall",  hz.reg_stall,  4'b0111);
      chk("t4_bubble", hz.reg_bubble, 4'b1000);
      chk("t4_no_jump", hz.jump_take, 1'b0);
      step();
    end
    hz.memory_i_busy = 1'b0;
    #1;
    chk("t4_jump_cycle4", hz.jump_take, 1'b1);
    chk("t4_pc_free",     hz.pc_stall,  1'b0);
    step();
    clearIn();
    chk("t4_flush2", hz.perf_flush, 64'd2);
    chk("t4_stall4", hz.perf_stall, 64'd4);

    $display("watchdog: execute busy held %0d cycles", WDOG);
    hz.execute_i_busy = 1'b1;
    for (int i = 1; i <= WDOG; i++) begin
      step();
      chk("t5_hang_edge", hz.hang, (i == WDOG));
    end
    hz.execute_i_busy = 1'b0;
    repeat (3) step();
    chk("t5_hang_sticky", hz.hang, 1'b1);

    $display("reset pulse during memory stall");
    hz.memory_i_busy = 1'b1;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid",   hz.stage_valid,  4'b0000);
    chk("t6_cycle",   hz.perf_cycle,   64'd0);
    chk("t6_instret", hz.perf_instret, 64'd0);
    chk("t6_bubble",  hz.reg_bubble,   4'b1111);
    chk("t6_stall",   hz.reg_stall,    4'b0000);
    chk("t6_pc",      hz.pc_stall,     1'b0);
    chk("t6_hang",    hz.hang,         1'b0);
    step();
    rst = 1'b0;
    hz.memory_i_busy = 1'b0;
    repeat (3) step();
    chk("t6_refill", hz.stage_valid, 4'b0111);
    chk("t6_cycle3", hz.perf_cycle,  64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
